// File: rtl/pong_cmd_pkg.sv
// Shared constants for the Pong remote-control frame decoder: header byte, opcodes, FSM states.
// Pure definitions, no logic; imported by the decoder and its interface users.
package pong_cmd_pkg;

    localparam logic [7:0] c_HDR      = 8'hA5;
    localparam logic [7:0] c_OP_START = 8'h01;
    localparam logic [7:0] c_OP_P1    = 8'h02;
    localparam logic [7:0] c_OP_P2    = 8'h03;
    localparam logic [7:0] c_OP_STOP  = 8'h04;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_OPCODE = 2'd1,
        S_ARG    = 2'd2,
        S_CSUM   = 2'd3
    } cmd_state_t;

    function automatic logic op_known(input logic [7:0] op);
        return (op >= c_OP_START) && (op <= c_OP_STOP);
    endfunction

endpackage

// File: rtl/pong_uart_cmd_decoder_if.sv
// Received-byte stream from the UART receiver: byte plus one-cycle valid strobe.
// No backpressure: the consumer must take one byte per cycle.
interface pong_uart_cmd_decoder_if;
    logic [7:0] i_RX_Byte;
    logic       i_RX_DV;

    modport master (output i_RX_Byte, output i_RX_DV);
    modport slave  (input  i_RX_Byte, input  i_RX_DV);
endinterface

// File: rtl/pong_cmd_hold_timer.sv
// One player's remote paddle up/down levels with self-expiry after c_CLKS_HOLD cycles.
// Levels update one cycle after load/neutral/clear; no backpressure.
module pong_cmd_hold_timer #(
    parameter int c_CLKS_HOLD = 2_500_000
) (
    input  logic i_Clk,
    input  logic i_Rst_L,
    input  logic i_Load,
    input  logic i_Neutral,
    input  logic i_Up,
    input  logic i_Dn,
    input  logic i_Clear,
    output logic o_Up,
    output logic o_Dn
);

    localparam int c_CNT_W = (c_CLKS_HOLD > 1) ? $clog2(c_CLKS_HOLD) : 1;

    logic [c_CNT_W-1:0] r_cnt;
    logic               r_up;
    logic               r_dn;

    // A new command takes priority over expiry in the same cycle.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_cnt <= '0;
            r_up  <= 1'b0;
            r_dn  <= 1'b0;
        end else if (i_Clear) begin
            r_cnt <= '0;
            r_up  <= 1'b0;
            r_dn  <= 1'b0;
        end else if (i_Load || i_Neutral) begin
            r_cnt <= c_CNT_W'(c_CLKS_HOLD - 1);
            r_up  <= i_Load & i_Up;
            r_dn  <= i_Load & i_Dn;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end else begin
            r_up  <= 1'b0;
            r_dn  <= 1'b0;
        end
    end

    assign o_Up = r_up;
    assign o_Dn = r_dn;

endmodule

// File: rtl/pong_uart_cmd_decoder.sv
// Decodes A5-framed UART commands into game start/stop pulses and self-expiring paddle levels; outputs registered,
// one cycle after the final byte strobe; no backpressure. PONG_CMD_CHECKSUM_EN selects the 4-byte checksummed frame.
module pong_uart_cmd_decoder
    import pong_cmd_pkg::*;
#(
    parameter int c_CLKS_HOLD    = 2_500_000,
    parameter int c_CLKS_TIMEOUT = 25_000
) (
    input  logic                          i_Clk,
    input  logic                          i_Rst_L,
    pong_uart_cmd_decoder_if.slave        rx,
    output logic                          o_Game_Start,
    output logic                          o_Game_Stop,
    output logic                          o_Paddle_Up_P1,
    output logic                          o_Paddle_Dn_P1,
    output logic                          o_Paddle_Up_P2,
    output logic                          o_Paddle_Dn_P2,
    output logic [7:0]                    o_Err_Count
);

    localparam int c_TO_W = (c_CLKS_TIMEOUT > 1) ? $clog2(c_CLKS_TIMEOUT) : 1;

    cmd_state_t        r_state;
    cmd_state_t        w_state_nxt;
    logic [7:0]        r_opcode;
    logic [c_TO_W-1:0] r_to_cnt;
    logic [7:0]        r_err_count;
    logic              r_start;
    logic              r_stop;

    logic              w_exec;
    logic              w_err;
    logic              w_timeout;
    logic [1:0]        w_arg_lo;
    logic              w_neutral;

`ifdef PONG_CMD_CHECKSUM_EN
    logic [7:0]        r_arg;
    assign w_arg_lo = r_arg[1:0];
`else
    // Without a checksum byte the arg byte itself triggers execution.
    assign w_arg_lo = rx.i_RX_Byte[1:0];
`endif

    assign w_timeout = (r_state != S_IDLE) && !rx.i_RX_DV
                       && (r_to_cnt == c_TO_W'(c_CLKS_TIMEOUT - 1));

    always_comb begin
        w_state_nxt = r_state;
        w_exec      = 1'b0;
        w_err       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (rx.i_RX_DV && rx.i_RX_Byte == c_HDR)
                    w_state_nxt = S_OPCODE;
            end
            S_OPCODE: begin
                if (rx.i_RX_DV) begin
                    w_state_nxt = S_ARG;
                end else if (w_timeout) begin
                    w_state_nxt = S_IDLE;
                    w_err       = 1'b1;
                end
            end
            S_ARG: begin
                if (rx.i_RX_DV) begin
`ifdef PONG_CMD_CHECKSUM_EN
                    w_state_nxt = S_CSUM;
`else
                    w_state_nxt = S_IDLE;
                    w_exec      = op_known(r_opcode);
                    w_err       = !op_known(r_opcode);
`endif
                end else if (w_timeout) begin
                    w_state_nxt = S_IDLE;
                    w_err       = 1'b1;
                end
            end
            S_CSUM: begin
`ifdef PONG_CMD_CHECKSUM_EN
                if (rx.i_RX_DV) begin
                    w_state_nxt = S_IDLE;
                    if ((rx.i_RX_Byte == (r_opcode ^ r_arg)) && op_known(r_opcode))
                        w_exec = 1'b1;
                    else
                        w_err  = 1'b1;
                end else if (w_timeout) begin
                    w_state_nxt = S_IDLE;
                    w_err       = 1'b1;
                end
`else
                w_state_nxt = S_IDLE;
`endif
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_state     <= S_IDLE;
            r_opcode    <= '0;
            r_to_cnt    <= '0;
            r_err_count <= '0;
            r_start     <= 1'b0;
            r_stop      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_OPCODE && rx.i_RX_DV)
                r_opcode <= rx.i_RX_Byte;
            // Counts idle cycles only while a frame is in progress.
            if (rx.i_RX_DV || r_state == S_IDLE || w_state_nxt == S_IDLE)
                r_to_cnt <= '0;
            else
                r_to_cnt <= r_to_cnt + 1'b1;
            if (w_err && r_err_count != 8'hFF)
                r_err_count <= r_err_count + 1'b1;
            r_start <= w_exec && (r_opcode == c_OP_START);
            r_stop  <= w_exec && (r_opcode == c_OP_STOP);
        end
    end

`ifdef PONG_CMD_CHECKSUM_EN
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L)
            r_arg <= '0;
        else if (r_state == S_ARG && rx.i_RX_DV)
            r_arg <= rx.i_RX_Byte;
    end
`endif

    assign w_neutral = (w_arg_lo == 2'b11);

    pong_cmd_hold_timer #(.c_CLKS_HOLD(c_CLKS_HOLD)) u_hold_p1 (
        .i_Clk     (i_Clk),
        .i_Rst_L   (i_Rst_L),
        .i_Load    (w_exec && r_opcode == c_OP_P1 && !w_neutral),
        .i_Neutral (w_exec && r_opcode == c_OP_P1 &&  w_neutral),
        .i_Up      (w_arg_lo[0]),
        .i_Dn      (w_arg_lo[1]),
        .i_Clear   (w_exec && r_opcode == c_OP_STOP),
        .o_Up      (o_Paddle_Up_P1),
        .o_Dn      (o_Paddle_Dn_P1)
    );

    pong_cmd_hold_timer #(.c_CLKS_HOLD(c_CLKS_HOLD)) u_hold_p2 (
        .i_Clk     (i_Clk),
        .i_Rst_L   (i_Rst_L),
        .i_Load    (w_exec && r_opcode == c_OP_P2 && !w_neutral),
        .i_Neutral (w_exec && r_opcode == c_OP_P2 &&  w_neutral),
        .i_Up      (w_arg_lo[0]),
        .i_Dn      (w_arg_lo[1]),
        .i_Clear   (w_exec && r_opcode == c_OP_STOP),
        .o_Up      (o_Paddle_Up_P2),
        .o_Dn      (o_Paddle_Dn_P2)
    );

    assign o_Game_Start = r_start;
    assign o_Game_Stop  = r_stop;
    assign o_Err_Count  = r_err_count;

endmodule

// File: tb/tb_pong_uart_cmd_decoder.sv
// Directed bench for pong_uart_cmd_decoder with short hold/timeout; expectations adapt to PONG_CMD_CHECKSUM_EN.
module tb_pong_uart_cmd_decoder;

    localparam int c_HOLD = 100;
    localparam int c_TO   = 50;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, stop, up1, dn1, up2, dn2;
    logic [7:0] err_cnt;

    int checks = 0;
    int errors = 0;
    int exp_err = 0;

    always #5 clk = ~clk;

    pong_uart_cmd_decoder_if rx_if ();

    pong_uart_cmd_decoder #(.c_CLKS_HOLD(c_HOLD), .c_CLKS_TIMEOUT(c_TO)) dut (
        .i_Clk          (clk),
        .i_Rst_L        (rst_n),
        .rx             (rx_if),
        .o_Game_Start   (start),
        .o_Game_Stop    (stop),
        .o_Paddle_Up_P1 (up1),
        .o_Paddle_Dn_P1 (dn1),
        .o_Paddle_Up_P2 (up2),
        .o_Paddle_Dn_P2 (dn2),
        .o_Err_Count    (err_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic put(input logic [7:0] b);
        @(negedge clk);
        rx_if.i_RX_DV   = 1'b1;
        rx_if.i_RX_Byte = b;
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        rx_if.i_RX_DV   = 1'b0;
        rx_if.i_RX_Byte = 8'h00;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] op, input logic [7:0] arg, input logic [7:0] cs);
        put(8'hA5);
        put(op);
        put(arg);
`ifdef PONG_CMD_CHECKSUM_EN
        put(cs);
`else
        if (cs == 8'h00) begin end
`endif
        idle(1);
    endtask

    initial begin
        rst_n           = 1'b0;
        rx_if.i_RX_DV   = 1'b0;
        rx_if.i_RX_Byte = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset_pulses",  {30'd0, start, stop}, 32'd0);
        chk("reset_paddles", {28'd0, up1, dn1, up2, dn2}, 32'd0);
        chk("reset_err",     {24'd0, err_cnt}, 32'd0);
        rst_n = 1'b1;
        idle(2);

        // START pulse exactly one cycle
        send_frame(8'h01, 8'h00, 8'h01);
        chk("start_rise", {30'd0, start, stop}, 32'b10);
        chk("start_err",  {24'd0, err_cnt}, 32'd0);
        idle(1);
        chk("start_fall", {31'd0, start}, 32'd0);

        // P1 up held for exactly c_HOLD cycles
        send_frame(8'h02, 8'h01, 8'h03);
        chk("p1_up_set", {28'd0, up1, dn1, up2, dn2}, 32'b1000);
        repeat (c_HOLD - 1) @(negedge clk);
        chk("p1_up_last", {28'd0, up1, dn1, up2, dn2}, 32'b1000);
        @(negedge clk);
        chk("p1_up_expired", {28'd0, up1, dn1, up2, dn2}, 32'b0000);

        // P2 down cleared by STOP
        send_frame(8'h03, 8'h02, 8'h01);
        chk("p2_dn_set", {28'd0, up1, dn1, up2, dn2}, 32'b0001);
        idle(10);
        send_frame(8'h04, 8'h00, 8'h04);
        chk("stop_pulse",   {30'd0, start, stop}, 32'b01);
        chk("stop_clears",  {28'd0, up1, dn1, up2, dn2}, 32'b0000);
        idle(1);
        chk("stop_fall", {31'd0, stop}, 32'd0);

        // Down then neutral on P1
        send_frame(8'h02, 8'h02, 8'h00);
        chk("p1_dn_set", {28'd0, up1, dn1, up2, dn2}, 32'b0100);
        send_frame(8'h02, 8'h03, 8'h01);
        chk("p1_neutral", {28'd0, up1, dn1, up2, dn2}, 32'b0000);
        chk("neutral_no_err", {24'd0, err_cnt}, exp_err);

`ifdef PONG_CMD_CHECKSUM_EN
        send_frame(8'h02, 8'h01, 8'hFF);
        exp_err++;
        chk("csum_err_cnt",   {24'd0, err_cnt}, exp_err);
        chk("csum_no_output", {28'd0, up1, dn1, up2, dn2}, 32'b0000);
`endif
        send_frame(8'h07, 8'h00, 8'h07);
        exp_err++;
        chk("badop_err_cnt", {24'd0, err_cnt}, exp_err);
        chk("badop_no_pulse", {30'd0, start, stop}, 32'd0);

        // Inter-byte timeout abandons the frame
        put(8'hA5);
        put(8'h02);
        idle(60);
        put(8'h01);
        put(8'h03);
        idle(1);
        exp_err++;
        chk("timeout_err_cnt", {24'd0, err_cnt}, exp_err);
        chk("timeout_no_paddle", {28'd0, up1, dn1, up2, dn2}, 32'b0000);

        // One idle cycle short of the timeout still completes the frame
        put(8'hA5);
        put(8'h02);
        idle(c_TO - 1);
        put(8'h01);
`ifdef PONG_CMD_CHECKSUM_EN
        put(8'h03);
`endif
        idle(1);
        chk("near_timeout_paddle", {28'd0, up1, dn1, up2, dn2}, 32'b1000);
        chk("near_timeout_err", {24'd0, err_cnt}, exp_err);

        // Refresh restarts the hold window
        idle(59);
        send_frame(8'h02, 8'h01, 8'h03);
        repeat (c_HOLD - 1) @(negedge clk);
        chk("refresh_held", {28'd0, up1, dn1, up2, dn2}, 32'b1000);
        @(negedge clk);
        chk("refresh_expired", {28'd0, up1, dn1, up2, dn2}, 32'b0000);

        // Error counter saturation
        for (int i = 0; i < 300; i++)
            send_frame(8'h07, 8'h00, 8'h07);
        exp_err = (exp_err + 300 > 255) ? 255 : exp_err + 300;
        chk("err_saturated", {24'd0, err_cnt}, exp_err);

        // Asynchronous reset mid-frame
        send_frame(8'h02, 8'h01, 8'h03);
        chk("pre_reset_paddle", {31'd0, up1}, 32'd1);
        put(8'hA5);
        put(8'h03);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_paddles", {28'd0, up1, dn1, up2, dn2}, 32'b0000);
        chk("async_rst_err", {24'd0, err_cnt}, 32'd0);
        rx_if.i_RX_DV = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        send_frame(8'h01, 8'h00, 8'h01);
        chk("post_rst_start", {30'd0, start, stop}, 32'b10);
        chk("post_rst_err", {24'd0, err_cnt}, 32'd0);

        idle(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pong_uart_cmd_decoder.md
# pong_uart_cmd_decoder

Frame parser between the UART receiver and the Pong game core. It consumes received bytes with their one-cycle valid strobe and decodes framed remote-control commands into a one-cycle game-start pulse, a one-cycle game-stop pulse, and per-player paddle up/down levels. Those outputs are ORed with the debounced push-button levels ahead of the game core. Paddle levels self-expire so a lost serial link cannot leave a paddle moving.

## Interface
- c_CLKS_HOLD, default 2_500_000: cycles a remote paddle command stays active without a refresh (100 ms at 25 MHz).
- c_CLKS_TIMEOUT, default 25_000: maximum idle cycles between bytes of one frame before the frame is abandoned.
- i_Clk  in  1  system clock, 25 MHz.
- i_Rst_L  in  1  reset, asynchronous, active-low.
- i_RX_Byte  in  8  received byte; valid only when i_RX_DV=1.
- i_RX_DV  in  1  one-cycle strobe, byte valid.
- o_Game_Start  out  1  one-cycle start pulse.
- o_Game_Stop  out  1  one-cycle stop pulse.
- o_Paddle_Up_P1, o_Paddle_Dn_P1, o_Paddle_Up_P2, o_Paddle_Dn_P2  out  1 each  remote paddle levels.
- o_Err_Count  out  8  saturating count of rejected frames.

## Operation
- Frame format: header 0xA5, opcode, arg, checksum (checksum = opcode XOR arg).
- Opcodes:
  - 0x01 START: o_Game_Start pulse; arg ignored.
  - 0x02 P1 paddle: arg[0]=up, arg[1]=down.
  - 0x03 P2 paddle: same arg encoding as P1.
  - 0x04 STOP: o_Game_Stop pulse, and all four paddle levels clear.
- FSM states:
  - S_IDLE: waits for a byte equal to 0xA5 and discards any other byte silently, then moves to S_OPCODE.
  - S_OPCODE: stores the opcode, then moves to S_ARG.
  - S_ARG: stores the arg, then moves to S_CSUM.
  - S_CSUM: compares the checksum and executes, then returns to S_IDLE.
- Bytes equal to 0xA5 after the header are treated as data. There is no mid-frame resync; the inter-byte timeout provides recovery.
- Paddle arg values:
  - arg[1:0]=2'b11 means neutral: both levels for that player go to 0 and the hold timer is reloaded. This is not an error.
  - arg[7:2] is ignored.
- A valid paddle frame loads that player's hold counter with c_CLKS_HOLD-1. Levels clear when the counter reaches 0.
- Error cases, each incrementing o_Err_Count (saturating at 255) and returning the FSM to S_IDLE:
  - checksum mismatch;
  - unknown opcode (0x00, 0x05–0xFF);
  - timeout: c_CLKS_TIMEOUT cycles with no i_RX_DV while in S_OPCODE, S_ARG or S_CSUM.
- A rejected frame produces no output change.
- Timeout counter: resets on every i_RX_DV and on entry to S_IDLE; it does not count in S_IDLE.

## Timing
- All outputs are registered. Reset values: every output 0, FSM in S_IDLE, all counters 0.
- Latency: the executing output changes in the cycle after the i_RX_DV that carries the final frame byte.
- Pulse width: o_Game_Start and o_Game_Stop are exactly 1 cycle wide.
- Paddle level duration: a level stays high for c_CLKS_HOLD cycles after it is set, unless refreshed, neutralised or stopped.
- Simultaneous events:
  - hold expiry in the same cycle as a new frame for that player: the new frame wins and the counter reloads;
  - timeout in the same cycle as i_RX_DV: the byte is accepted and no timeout is counted.
- Back-to-back i_RX_DV on consecutive cycles must be accepted (one byte per cycle).
- Reset asserted mid-frame: the FSM returns to S_IDLE immediately; the partial frame is lost and not counted as an error.

## Configuration
- PONG_CMD_CHECKSUM_EN defined: 4-byte frame; the checksum is checked as described above.
- PONG_CMD_CHECKSUM_EN undefined: 3-byte frame (header, opcode, arg). S_CSUM is not built; execution happens on the arg byte with the same one-cycle latency. Checksum errors cannot occur.

## Structure
- Shared package pong_cmd_pkg holds:
  - the header constant 0xA5;
  - opcode constants: START, P1, P2, STOP;
  - the FSM state encoding.
- Sub-module pong_cmd_hold_timer, instantiated once per player, holds:
  - the up/down level registers;
  - the load, neutral and clear inputs;
  - the down-counter of width $clog2(c_CLKS_HOLD).

## Test plan
- Frame A5 01 00 01 -> o_Game_Start high exactly 1 cycle, 1 cycle after the last i_RX_DV; o_Err_Count stays 0.
- With c_CLKS_HOLD=100, frame A5 02 01 03 -> o_Paddle_Up_P1=1 for exactly 100 cycles, then 0; P2 outputs unaffected.
- Frame A5 03 02 01, then A5 04 00 04 after 10 cycles -> o_Paddle_Dn_P2 rises, then clears in the same cycle o_Game_Stop pulses.
- Frame A5 02 01 FF -> no output change, o_Err_Count=1. Next, A5 07 00 07 -> o_Err_Count=2.
- With c_CLKS_TIMEOUT=50, send A5 02 then 60 idle cycles, then 01 03 -> error counted and no paddle activity; a subsequent full valid frame works.
- 300 bad frames -> o_Err_Count saturates at 255. Assert i_Rst_L low mid-frame -> all outputs 0 asynchronously.
